imem_loader: RTL and testbench

Boot-time writer for the instruction memory. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It issues one write strobe per word to the writable port of the 64-word instruction memory, starting at word address 0. It holds the processor in reset (`cpu_hold`) until the image is complete, then releases it.

---
 rtl/imem_loader_if.sv | 22 ++
 rtl/imem_loader.sv | 127 ++++++++++++
 tb/tb_imem_loader.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write-port bundle for imem_loader.
// The master side is the loader; the slave side is the byte source plus the memory.
interface imem_loader_if #(
  parameter int ADDR_W = 6
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, we, waddr, wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, we, waddr, wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: byte stream -> big-endian words written to the instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to add a trailing XOR checksum byte and the err flag.
module imem_loader #(
  parameter int ADDR_W = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          cpu_hold
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] last_idx;   // N-1, so a full 2^ADDR_W image fits the counter
  logic [ADDR_W-1:0] word_cnt;
  logic [1:0]        byte_cnt;
  logic [23:0]       asm_q;      // the 4th byte goes straight to wdata
  logic              accept;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       err_q;

  assign bus.rx_ready = (state == S_COUNT) || (state == S_DATA) || (state == S_CHECK);
  assign err          = err_q;
`else
  assign bus.rx_ready = (state == S_COUNT) || (state == S_DATA);
  assign err          = 1'b0;
`endif

  assign accept   = bus.rx_valid && bus.rx_ready;
  assign busy     = bus.rx_ready;
  assign cpu_hold = (state != S_DONE);

  // NOTE: every register here, including the assembler, is a flop with an async
  // reset and is written only with <=, so all reads in this block see pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      last_idx  <= '0;
      word_cnt  <= '0;
      byte_cnt  <= '0;
      asm_q     <= '0;
      bus.we    <= 1'b0;
      bus.waddr <= '0;
      bus.wdata <= '0;
      done      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      bus.we <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= S_COUNT;
            done     <= 1'b0;
            word_cnt <= '0;
            byte_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= '0;
            err_q    <= 1'b0;
`endif
          end
        end

        S_COUNT: begin
          if (accept) begin
            last_idx <= bus.rx_data[ADDR_W-1:0];
            state    <= S_DATA;
          end
        end

        S_DATA: begin
          if (accept) begin
            asm_q    <= {asm_q[15:0], bus.rx_data};
            byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= csum ^ bus.rx_data;
`endif
            if (byte_cnt == 2'd3) begin
              bus.we    <= 1'b1;
              bus.waddr <= word_cnt;
              bus.wdata <= {asm_q, bus.rx_data};
              word_cnt  <= word_cnt + ADDR_W'(1);
              if (word_cnt == last_idx) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state <= S_CHECK;
`else
                state <= S_DONE;
                done  <= 1'b1;
`endif
              end
            end
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (accept) begin
            err_q <= (bus.rx_data != csum);
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
`endif

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset, single word, full image, count masking,
// stall/start-ignore, reset mid-load, and (with IMEM_LOADER_CHECKSUM_EN) the checksum.
module tb_imem_loader;
  localparam int ADDR_W = 6;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, err, cpu_hold;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .bus      (bus.master),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cpu_hold (cpu_hold)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [ADDR_W-1:0] wa_q[$];
  logic [31:0]       wd_q[$];
  logic [7:0]        xr;

  // Write-port monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      wa_q.push_back(bus.waddr);
      wd_q.push_back(bus.wdata);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one byte at a negedge; it is accepted on the following posedge.
  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    check("rx_ready_on_send", bus.rx_ready, 1'b1);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] b);
    send(b);
    xr = xr ^ b;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int j = 3; j >= 0; j--) send_data(w[8*j +: 8]);
  endtask

  task automatic gap(input int n);
    bus.rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic start_load();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    xr = 8'h00;
    wa_q.delete();
    wd_q.delete();
  endtask

  // Completes a load: sends the trailer only when the checksum stage exists.
  task automatic end_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(xr);
`endif
  endtask

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;

    // ---- reset during idle ----
    @(negedge clk);
    check("rst_rx_ready", bus.rx_ready, 1'b0);
    check("rst_we",       bus.we,       1'b0);
    check("rst_waddr",    bus.waddr,    '0);
    check("rst_wdata",    bus.wdata,    32'h0);
    check("rst_busy",     busy,         1'b0);
    check("rst_done",     done,         1'b0);
    check("rst_err",      err,          1'b0);
    check("rst_cpu_hold", cpu_hold,     1'b1);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("idle_rx_ready", bus.rx_ready, 1'b0);
    check("idle_no_we",    wa_q.size(),  0);
    check("idle_cpu_hold", cpu_hold,     1'b1);

    // ---- single word DEADBEEF ----
    start_load();
    check("sw_busy",      busy,         1'b1);
    check("sw_rx_ready",  bus.rx_ready, 1'b1);
    check("sw_cpu_hold0", cpu_hold,     1'b1);
    send(8'h00);
    send_word(32'hDEADBEEF);
    check("sw_we",    bus.we,    1'b1);
    check("sw_waddr", bus.waddr, 6'd0);
    check("sw_wdata", bus.wdata, 32'hDEADBEEF);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("sw_done_pending", done, 1'b0);
    check("sw_busy_check",   busy, 1'b1);
    end_load();
`endif
    check("sw_done",     done,         1'b1);
    check("sw_cpu_hold", cpu_hold,     1'b0);
    check("sw_busy_off", busy,         1'b0);
    check("sw_rx_off",   bus.rx_ready, 1'b0);
    @(negedge clk);
    check("sw_we_pulse", bus.we,    1'b0);
    check("sw_hold_wd",  bus.wdata, 32'hDEADBEEF);
    check("sw_done_st",  done,      1'b1);
    check("sw_err",      err,       1'b0);

    // ---- full 64-word image with random valid gaps ----
    start_load();
    check("img_done_clr", done,     1'b0);
    check("img_hold",     cpu_hold, 1'b1);
    send(8'h3F);
    for (int i = 0; i < 64; i++) begin
      logic [7:0] b;
      b = i[7:0];
      for (int j = 0; j < 4; j++) begin
        if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
        send_data(b);
      end
      if (i == 62) check("img_done_early", done, 1'b0);
    end
    end_load();
    @(negedge clk);
    #1;
    check("img_count", wa_q.size(), 64);
    if (wa_q.size() == 64) begin
      for (int i = 0; i < 64; i++) begin
        logic [7:0] b;
        b = i[7:0];
        check("img_addr", wa_q[i], i[ADDR_W-1:0]);
        check("img_data", wd_q[i], {b, b, b, b});
      end
    end
    check("img_done",     done,     1'b1);
    check("img_cpu_hold", cpu_hold, 1'b0);

    // ---- count byte C1 behaves as 01: two words ----
    start_load();
    send(8'hC1);
    send_word(32'h01020304);
    check("c1_not_done", done, 1'b0);
    check("c1_busy",     busy, 1'b1);
    send_word(32'hA5A55A5A);
    end_load();
    @(negedge clk);
    #1;
    check("c1_count", wa_q.size(), 2);
    if (wa_q.size() == 2) begin
      check("c1_a0", wa_q[0], 6'd0);
      check("c1_d0", wd_q[0], 32'h01020304);
      check("c1_a1", wa_q[1], 6'd1);
      check("c1_d1", wd_q[1], 32'hA5A55A5A);
    end
    check("c1_done", done, 1'b1);

    // ---- stall of 7 cycles mid-word with a start pulse in DATA ----
    start_load();
    send(8'h01);
    send_data(8'hA1);
    send_data(8'hB2);
    gap(3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    gap(3);
    #1;
    check("st_busy",   busy,         1'b1);
    check("st_ready",  bus.rx_ready, 1'b1);
    check("st_done",   done,         1'b0);
    check("st_no_we",  wa_q.size(),  0);
    send_data(8'hC3);
    send_data(8'hD4);
    #1;
    check("st_we_cnt", wa_q.size(), 1);
    check("st_wdata",  bus.wdata,   32'hA1B2C3D4);
    check("st_waddr",  bus.waddr,   6'd0);
    send_word(32'h11223344);
    end_load();
    @(negedge clk);
    #1;
    check("st_total",  wa_q.size(), 2);
    check("st_wdata1", bus.wdata,   32'h11223344);
    check("st_waddr1", bus.waddr,   6'd1);
    check("st_fin",    done,        1'b1);

    // ---- reset mid-load after 2 bytes of word 3 ----
    start_load();
    send(8'h07);
    send_word(32'h10000000);
    send_word(32'h20000000);
    send_word(32'h30000000);
    send_data(8'h40);
    send_data(8'h41);
    reset_n = 1'b0;
    #1;
    check("mr_we",       bus.we,       1'b0);
    check("mr_busy",     busy,         1'b0);
    check("mr_rx_ready", bus.rx_ready, 1'b0);
    check("mr_cpu_hold", cpu_hold,     1'b1);
    check("mr_waddr",    bus.waddr,    '0);
    check("mr_wdata",    bus.wdata,    32'h0);
    check("mr_written",  wa_q.size(),  3);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("mr_no_more_we", wa_q.size(), 3);
    check("mr_idle",       busy,        1'b0);
    start_load();
    send(8'h00);
    send_word(32'hCAFEF00D);
    end_load();
    @(negedge clk);
    #1;
    check("mr_new_cnt",  wa_q.size(), 1);
    if (wa_q.size() == 1) begin
      check("mr_new_addr", wa_q[0], 6'd0);
      check("mr_new_data", wd_q[0], 32'hCAFEF00D);
    end
    check("mr_new_done", done, 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // ---- checksum: correct trailer, then wrong trailer ----
    start_load();
    send(8'h00);
    send_word(32'h12345678);
    check("ck_in_check", busy, 1'b1);
    check("ck_pending",  done, 1'b0);
    send(8'h08);
    check("ck_ok_done", done,     1'b1);
    check("ck_ok_err",  err,      1'b0);
    check("ck_ok_hold", cpu_hold, 1'b0);
    start_load();
    send(8'h00);
    send_word(32'h12345678);
    send(8'h09);
    check("ck_bad_done", done,     1'b1);
    check("ck_bad_err",  err,      1'b1);
    check("ck_bad_hold", cpu_hold, 1'b0);
    start_load();
    check("ck_err_clr",  err,      1'b0);
`else
    check("no_ck_err", err, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
